// File: rtl/arq_pkg.sv
// Shared types and default parameter values for the stop-and-wait ARQ transmitter.
package arq_pkg;

  localparam int unsigned ARQ_DATA_W_DEF    = 8;
  localparam int unsigned ARQ_TIMEOUT_DEF   = 64;
  localparam int unsigned ARQ_MAX_RETRY_DEF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } arq_state_e;

endpackage

// File: rtl/arq_timer.sv
// Acknowledgement timeout counter: counts while enabled, saturates at TIMEOUT-1.
module arq_timer
  import arq_pkg::*;
#(
  parameter int unsigned TIMEOUT = ARQ_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Saturating so the count can never wrap back to zero inside WAIT.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/arq_tx_ctrl.sv
// Stop-and-wait (alternating-bit) ARQ transmit controller with timeout-driven retransmission.
module arq_tx_ctrl
  import arq_pkg::*;
#(
  parameter int unsigned DATA_W    = ARQ_DATA_W_DEF,
  parameter int unsigned TIMEOUT   = ARQ_TIMEOUT_DEF,
  parameter int unsigned MAX_RETRY = ARQ_MAX_RETRY_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [DATA_W-1:0] req_data,
  output logic              req_ready,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_seq,
  input  logic              tx_ready,
  input  logic              ack_valid,
  input  logic              ack_seq,
  output logic              done,
  output logic              fail,
  output logic              busy
);

  localparam logic [3:0] RETRY_LIM = 4'(MAX_RETRY);

  arq_state_e        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              seq_q, seq_d;
  logic [3:0]        retry_q, retry_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;
  logic              expired;

  arq_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q != WAIT),
    .enable  (state_q == WAIT),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    seq_d   = seq_q;
    retry_d = retry_q;
    done_d  = 1'b0;
    fail_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          data_d  = req_data;
          retry_d = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A matching ACK wins over a timeout landing in the same cycle.
        if (ack_valid && (ack_seq == seq_q)) begin
          done_d  = 1'b1;
          seq_d   = ~seq_q;
          state_d = IDLE;
        end else if (expired) begin
          if (retry_q < RETRY_LIM) begin
            retry_d = retry_q + 1'b1;
            state_d = SEND;
          end else begin
            fail_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      seq_q   <= 1'b0;
      retry_q <= '0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      seq_q   <= seq_d;
      retry_q <= retry_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign tx_valid  = (state_q == SEND);
  assign tx_data   = data_q;
  assign tx_seq    = seq_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign fail      = fail_q;

endmodule

// File: tb/tb_arq_tx_ctrl.sv
// Directed bench for arq_tx_ctrl at default parameters (DATA_W=8, TIMEOUT=64, MAX_RETRY=3).
module tb_arq_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic [7:0] req_data;
  logic       req_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_seq;
  logic       tx_ready;
  logic       ack_valid;
  logic       ack_seq;
  logic       done;
  logic       fail;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;

  arq_tx_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_seq    (tx_seq),
    .tx_ready  (tx_ready),
    .ack_valid (ack_valid),
    .ack_seq   (ack_seq),
    .done      (done),
    .fail      (fail),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one payload for a single cycle; returns with the controller in SEND.
  task automatic send_frame(input logic [7:0] d);
    chk("accept_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_data  = d;
    step();
    req_valid = 1'b0;
    req_data  = 8'h00;
  endtask

  // Steps until tx_valid reappears; returns the number of edges taken (bounded).
  task automatic wait_retx(output int cnt);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      cnt++;
      if (tx_valid) break;
    end
  endtask

  initial begin
    int cnt;
    int nsend;
    int fail_seen;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_data  = 8'h00;
    tx_ready  = 1'b0;
    ack_valid = 1'b0;
    ack_seq   = 1'b0;
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_tx_valid",  32'(tx_valid),  32'd0);
    chk("rst_tx_data",   32'(tx_data),   32'd0);
    chk("rst_tx_seq",    32'(tx_seq),    32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_fail",      32'(fail),      32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Normal send, seq 0 then seq 1
    tx_ready = 1'b1;
    send_frame(8'hA5);
    chk("n_tx_valid", 32'(tx_valid), 32'd1);
    chk("n_tx_data",  32'(tx_data),  32'hA5);
    chk("n_tx_seq",   32'(tx_seq),   32'd0);
    chk("n_busy",     32'(busy),     32'd1);
    chk("n_ready",    32'(req_ready), 32'd0);
    step();
    chk("n_wait_txv", 32'(tx_valid), 32'd0);
    chk("n_wait_bsy", 32'(busy),     32'd1);
    step();
    step();
    ack_valid = 1'b1;
    ack_seq   = 1'b0;
    step();
    ack_valid = 1'b0;
    chk("n_done",      32'(done), 32'd1);
    chk("n_no_fail",   32'(fail), 32'd0);
    chk("n_idle_busy", 32'(busy), 32'd0);
    step();
    chk("n_done_pulse", 32'(done), 32'd0);
    send_frame(8'h5A);
    chk("n2_tx_seq",  32'(tx_seq),  32'd1);
    chk("n2_tx_data", 32'(tx_data), 32'h5A);
    step();
    ack_valid = 1'b1;
    ack_seq   = 1'b1;
    step();
    ack_valid = 1'b0;
    chk("n2_done", 32'(done), 32'd1);

    // Single timeout, seq 0
    send_frame(8'h3C);
    step();
    wait_retx(cnt);
    chk("t_retx_delay", 32'(cnt),     32'd64);
    chk("t_retx_data",  32'(tx_data), 32'h3C);
    chk("t_retx_seq",   32'(tx_seq),  32'd0);
    step();
    ack_valid = 1'b1;
    ack_seq   = 1'b0;
    step();
    ack_valid = 1'b0;
    chk("t_done",  32'(done),         32'd1);
    chk("t_retry", 32'(dut.retry_q),  32'd1);

    // Stale ACK, then matching ACK on the last timer cycle; seq 1
    send_frame(8'hC3);
    step();
    ack_valid = 1'b1;
    ack_seq   = 1'b0;
    step();
    ack_valid = 1'b0;
    chk("s_stale_done", 32'(done), 32'd0);
    chk("s_stale_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 62; i++) step();
    chk("s_still_wait", 32'(tx_valid), 32'd0);
    ack_valid = 1'b1;
    ack_seq   = 1'b1;
    step();
    ack_valid = 1'b0;
    chk("s_edge_done",  32'(done),     32'd1);
    chk("s_edge_noretx", 32'(tx_valid), 32'd0);
    chk("s_edge_busy",  32'(busy),     32'd0);
    step();
    chk("s_after_txv",  32'(tx_valid), 32'd0);

    // Backpressure with an ACK arriving during SEND; seq 0
    tx_ready = 1'b0;
    send_frame(8'h77);
    for (int i = 0; i < 5; i++) begin
      chk("b_tx_valid", 32'(tx_valid), 32'd1);
      chk("b_tx_data",  32'(tx_data),  32'h77);
      chk("b_tx_seq",   32'(tx_seq),   32'd0);
      chk("b_no_done",  32'(done),     32'd0);
      ack_valid = (i == 2);
      ack_seq   = 1'b0;
      step();
    end
    ack_valid = 1'b0;
    chk("b_held",    32'(tx_valid), 32'd1);
    chk("b_no_done2", 32'(done),    32'd0);
    tx_ready = 1'b1;
    step();
    chk("b_hs_txv", 32'(tx_valid), 32'd0);
    wait_retx(cnt);
    chk("b_retx_delay", 32'(cnt), 32'd64);
    step();
    ack_valid = 1'b1;
    ack_seq   = 1'b0;
    step();
    ack_valid = 1'b0;
    chk("b_done", 32'(done), 32'd1);

    // Abort after MAX_RETRY retransmissions; seq 1 stays
    send_frame(8'h99);
    nsend     = 0;
    fail_seen = 0;
    for (int i = 0; i < 400; i++) begin
      if (tx_valid) begin
        nsend++;
        chk("a_tx_data", 32'(tx_data), 32'h99);
        chk("a_tx_seq",  32'(tx_seq),  32'd1);
      end
      if (fail) begin
        fail_seen = 1;
        break;
      end
      step();
    end
    chk("a_fail_seen", 32'(fail_seen), 32'd1);
    chk("a_tx_count",  32'(nsend),     32'd4);
    chk("a_no_done",   32'(done),      32'd0);
    chk("a_idle",      32'(busy),      32'd0);
    chk("a_seq_kept",  32'(tx_seq),    32'd1);
    step();
    chk("a_fail_pulse", 32'(fail), 32'd0);

    // Reset in WAIT
    send_frame(8'h42);
    step();
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("r_tx_valid",  32'(tx_valid),  32'd0);
    chk("r_tx_data",   32'(tx_data),   32'd0);
    chk("r_tx_seq",    32'(tx_seq),    32'd0);
    chk("r_busy",      32'(busy),      32'd0);
    chk("r_req_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("r_no_done", 32'(done), 32'd0);
      chk("r_no_fail", 32'(fail), 32'd0);
    end
    rst_n = 1'b1;
    step();
    chk("r_post_done", 32'(done), 32'd0);
    send_frame(8'hE7);
    chk("r_new_seq",  32'(tx_seq),  32'd0);
    chk("r_new_data", 32'(tx_data), 32'hE7);
    step();
    ack_valid = 1'b1;
    ack_seq   = 1'b0;
    step();
    ack_valid = 1'b0;
    chk("r_new_done", 32'(done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/arq_tx_ctrl.md
ARQ_TX_CTRL -- requirements
Module: arq_tx_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, frame payload width in bits.
REQ-002 Parameter TIMEOUT, default 64, number of cycles spent in WAIT before retransmission; legal range 2..1023.
REQ-003 Parameter MAX_RETRY, default 3, number of retransmissions allowed before abort; legal range 0..15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  input  1  upstream has a payload to send.
REQ-007 req_data  input  DATA_W  upstream payload.
REQ-008 req_ready  output  1  controller accepts a payload this cycle.
REQ-009 tx_valid  output  1  frame presented to link.
REQ-010 tx_data  output  DATA_W  frame payload.
REQ-011 tx_seq  output  1  alternating-bit sequence number of the frame.
REQ-012 tx_ready  input  1  link accepts the frame this cycle.
REQ-013 ack_valid  input  1  acknowledgement received from the receiver side, one-cycle pulse.
REQ-014 ack_seq  input  1  sequence number carried by the acknowledgement.
REQ-015 done  output  1  one-cycle pulse: current payload acknowledged.
REQ-016 fail  output  1  one-cycle pulse: current payload abandoned after MAX_RETRY retransmissions.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, SEND and WAIT.
REQ-019 In IDLE, req_ready SHALL be 1; in all other states it SHALL be 0.
REQ-020 On req_valid&&req_ready, the block SHALL latch req_data, clear the retry count to 0, and enter SEND; tx_valid SHALL rise on the next cycle (acceptance-to-tx latency 1 cycle).
REQ-021 In SEND, tx_valid SHALL be 1, and tx_data/tx_seq SHALL hold the latched payload and the current seq bit, stable until tx_valid&&tx_ready.
REQ-022 On tx_valid&&tx_ready, the block SHALL clear the timer to 0 and enter WAIT.
REQ-023 In WAIT, the timer SHALL increment by 1 per cycle.
REQ-024 A matching acknowledgement is ack_valid=1 with ack_seq==seq; in WAIT it SHALL pulse done for one cycle, toggle seq, and return to IDLE.
REQ-025 ack_valid with ack_seq!=seq (duplicate/stale ACK) SHALL be ignored.
REQ-026 ack_valid outside WAIT SHALL be ignored.
REQ-027 If the timer reaches TIMEOUT-1 with no matching ACK and retry<MAX_RETRY, the block SHALL increment retry and re-enter SEND with the same payload and seq.
REQ-028 If the timer reaches TIMEOUT-1 with no matching ACK and retry==MAX_RETRY, the block SHALL pulse fail for one cycle, return to IDLE, and leave seq unchanged.
REQ-029 A matching ACK in the same cycle as timer==TIMEOUT-1 SHALL take priority: done, no retransmission.
REQ-030 done and fail SHALL never be asserted in the same cycle.
REQ-031 The timer SHALL be ceil(log2(TIMEOUT)) bits wide and SHALL never wrap within WAIT.

Reset
REQ-032 While rst_n=0, the FSM SHALL be in IDLE; seq, retry and timer SHALL be 0; the latched data SHALL be 0.
REQ-033 While rst_n=0, the outputs SHALL be tx_valid=0, tx_data=0, tx_seq=0, done=0, fail=0, busy=0, and req_ready=1.
REQ-034 Reset asserted mid-frame SHALL discard the payload without a done or fail pulse.

Structure
REQ-035 A shared package arq_pkg SHALL hold the FSM state enum (IDLE/SEND/WAIT) and the default constants for DATA_W, TIMEOUT and MAX_RETRY.
REQ-036 The timeout counter SHALL be a sub-module arq_timer with inputs clear and enable, parameter TIMEOUT, and output expired.
REQ-037 All other logic SHALL be in arq_tx_ctrl.

Verification
REQ-038 Scenario, normal send: send 0xA5 with tx_ready=1, then a matching ACK with seq 0 three cycles after the send -> tx_valid one cycle after acceptance, tx_seq=0, done pulse, the next frame uses tx_seq=1.
REQ-039 Scenario, single timeout: send 0x3C with no ACK -> retransmission of 0x3C with the same seq after 64 WAIT cycles, then a matching ACK -> done, retry count 1.
REQ-040 Scenario, abort: MAX_RETRY=3 with ACKs never sent -> exactly 4 transmissions, then a fail pulse, IDLE, and seq unchanged.
REQ-041 Scenario, stale ACK: an ACK with the wrong seq in WAIT -> ignored and the timeout proceeds; a matching ACK on the timer==TIMEOUT-1 cycle -> done, no retransmit.
REQ-042 Scenario, backpressure: tx_ready=0 for 5 cycles -> tx_valid, tx_data and tx_seq held stable, and the timer does not start until the handshake.
REQ-043 Scenario, reset: rst_n dropped in WAIT -> all outputs at reset values immediately, no done or fail pulse, and the next frame uses seq 0.
